// File: rtl/muldiv_ops_pkg.sv
// rtl/muldiv_ops_pkg.sv - shared multiply/divide op encodings, opcodes, trap causes and FSM states
package muldiv_ops;

    // M-extension funct3 ordering: bit 2 set means a divide-class op.
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [6:0] {
        OPC_OP    = 7'b0110011,
        OPC_OP_32 = 7'b0111011
    } opcode_t;

    typedef enum logic [3:0] {
        TRAP_INSN_MISALIGNED = 4'd0,
        TRAP_INSN_FAULT      = 4'd1,
        TRAP_ILLEGAL_INSN    = 4'd2
    } trap_cause_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_SPECIAL,
        S_DONE
    } muldiv_state_t;

    function automatic logic op_is_mul(input muldiv_op_t op);
        return !op[2];
    endfunction

    function automatic logic op_is_signed_div(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input muldiv_op_t op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/exec_div_core.sv
// rtl/exec_div_core.sv - unsigned iterative restoring divider, DIV_STEP quotient bits per cycle
//
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   start                load operands and begin (ignored unless idle by contract)
//   abort                drop the current division
//   word                 1: 32-bit division of the low word, 0: full XLEN
//   dividend, divisor    unsigned magnitudes (upper bits zero when word=1)
//   busy                 iterations remaining
//   done                 one-cycle pulse once quotient/remainder are final
//   quotient, remainder  results, stable until the next start
module exec_div_core #(
    parameter int XLEN     = 64,
    parameter int DIV_STEP = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(XLEN / DIV_STEP + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN / DIV_STEP);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(32 / DIV_STEP);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q, quo_q, div_q;
    logic [XLEN-1:0]  rem_n, quo_n;
    logic [XLEN:0]    part;
    logic             done_q;

    // quo_q doubles as the dividend shift register: dividend bits leave the
    // top while quotient bits enter at the bottom.
    always_comb begin
        rem_n = rem_q;
        quo_n = quo_q;
        part  = '0;
        for (int i = 0; i < DIV_STEP; i++) begin
            part  = {rem_n, quo_n[XLEN-1]};
            quo_n = {quo_n[XLEN-2:0], 1'b0};
            if (part >= {1'b0, div_q}) begin
                part     = part - {1'b0, div_q};
                quo_n[0] = 1'b1;
            end
            rem_n = part[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            cnt_q  <= word ? CNT_WORD : CNT_FULL;
            rem_q  <= '0;
            // Word divides pre-align the low word to the top so only 32 shifts are needed.
            quo_q  <= word ? (dividend << (XLEN - 32)) : dividend;
            div_q  <= divisor;
            done_q <= 1'b0;
        end else if (abort) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            cnt_q  <= cnt_q - CNT_ONE;
            rem_q  <= rem_n;
            quo_q  <= quo_n;
            done_q <= (cnt_q == CNT_ONE);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign busy      = (cnt_q != '0);
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/exec_muldiv.sv
// rtl/exec_muldiv.sv - integer multiply/divide execution unit, one op in flight
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   in_valid/in_ready            op handshake; in_ready only in IDLE
//   in_op, in_word               operation and 32-bit (W) variant select
//   in_a, in_b, in_tag           operands and opaque tag
//   flush                        kill any in-flight op, return to IDLE
//   out_valid/out_ready          result handshake; result held until taken
//   out_result, out_tag          result and tag, zero while out_valid=0
module exec_muldiv
    import muldiv_ops::*;
#(
    parameter int XLEN     = 64,
    parameter int DIV_STEP = 2,
    parameter int MUL_LAT  = 2,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  muldiv_op_t       in_op,
    input  logic             in_word,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int MCNT_W = $clog2(MUL_LAT) + 1;
    localparam logic [MCNT_W-1:0] MCNT_ONE = MCNT_W'(1);
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [31:0]     INT_MIN32 = 32'h8000_0000;

    muldiv_state_t state_q, state_n;
    logic [MCNT_W-1:0] mul_cnt_q;
    logic [XLEN-1:0]   mul_pipe_q [MUL_LAT];
    logic [XLEN-1:0]   result_q;
    logic [TAG_W-1:0]  tag_q;
    logic              neg_q_q, neg_r_q, is_rem_q, word_q;

    logic              accept, is_mul, is_rem, signed_div;
    logic              a_neg, b_neg, b_zero, ovf, is_special;
    logic [XLEN-1:0]   a_n, b_n, a_mag, b_mag, a_sext, special_res;
    logic              a_sx, b_sx;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_sel;
    logic [XLEN-1:0]   dq, dr, dv, div_res;
    logic [XLEN-1:0]   div_quo, div_rem;
    logic              div_start, div_busy, div_done;

    assign in_ready   = (state_q == S_IDLE);
    assign accept     = in_valid & in_ready & ~flush;
    assign is_mul     = op_is_mul(in_op);
    assign is_rem     = op_is_rem(in_op);
    assign signed_div = op_is_signed_div(in_op);

    // Operand preparation: width-N values, signs, magnitudes and the
    // divide-by-zero / INT_MIN/-1 results that bypass the iterative core.
    always_comb begin
        a_n    = in_word ? (signed_div ? XLEN'($signed(in_a[31:0])) : XLEN'(in_a[31:0])) : in_a;
        b_n    = in_word ? (signed_div ? XLEN'($signed(in_b[31:0])) : XLEN'(in_b[31:0])) : in_b;
        a_neg  = signed_div & (in_word ? in_a[31] : in_a[XLEN-1]);
        b_neg  = signed_div & (in_word ? in_b[31] : in_b[XLEN-1]);
        a_mag  = a_neg ? -a_n : a_n;
        b_mag  = b_neg ? -b_n : b_n;
        b_zero = in_word ? (in_b[31:0] == 32'd0) : (in_b == '0);
        ovf    = signed_div & (in_word ? ((in_a[31:0] == INT_MIN32) && (&in_b[31:0]))
                                       : ((in_a == INT_MIN) && (&in_b)));
        is_special = b_zero | ovf;
        a_sext = in_word ? XLEN'($signed(in_a[31:0])) : in_a;
        if (b_zero) begin
            special_res = is_rem ? a_sext : '1;
        end else begin
            special_res = is_rem ? '0 : (in_word ? XLEN'($signed(INT_MIN32)) : INT_MIN);
        end
    end

    // Sign-extending both operands to 2*XLEN makes the low 2*XLEN bits of an
    // unsigned product equal to the signed/mixed product.
    always_comb begin
        a_sx = ((in_op == OP_MULH) || (in_op == OP_MULHSU)) & in_a[XLEN-1];
        b_sx = (in_op == OP_MULH) & in_b[XLEN-1];
        prod = {{XLEN{a_sx}}, in_a} * {{XLEN{b_sx}}, in_b};
        if (in_word) begin
            mul_sel = (in_op == OP_MUL) ? XLEN'($signed(prod[31:0])) : '0;
        end else begin
            mul_sel = (in_op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        dq      = neg_q_q ? -div_quo : div_quo;
        dr      = neg_r_q ? -div_rem : div_rem;
        dv      = is_rem_q ? dr : dq;
        div_res = word_q ? XLEN'($signed(dv[31:0])) : dv;
    end

    assign div_start = accept & ~is_mul & ~is_special;

    exec_div_core #(
        .XLEN     (XLEN),
        .DIV_STEP (DIV_STEP)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush),
        .word      (in_word),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul)          state_n = S_MUL;
                    else if (is_special) state_n = S_SPECIAL;
                    else                 state_n = S_DIV;
                end
            end
            S_MUL:     if (mul_cnt_q == '0) state_n = S_DONE;
            S_DIV: begin
                if (div_done)       state_n = S_DONE;
                else if (!div_busy) state_n = S_IDLE;
            end
            S_SPECIAL: state_n = S_DONE;
            S_DONE:    if (out_ready) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
        if (flush) state_n = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            mul_cnt_q <= '0;
        end else begin
            state_q <= state_n;
            if (accept) begin
                mul_cnt_q <= MCNT_W'(MUL_LAT - 1);
            end else if ((state_q == S_MUL) && (mul_cnt_q != '0)) begin
                mul_cnt_q <= mul_cnt_q - MCNT_ONE;
            end
        end
    end

    // Stage 0 is the registered product; the rest are plain retiming stages.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < MUL_LAT; i++) mul_pipe_q[i] <= '0;
        end else begin
            if (accept) mul_pipe_q[0] <= mul_sel;
            for (int i = 1; i < MUL_LAT; i++) mul_pipe_q[i] <= mul_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            result_q <= '0;
            tag_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            is_rem_q <= 1'b0;
            word_q   <= 1'b0;
        end else if (accept) begin
            tag_q    <= in_tag;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            is_rem_q <= is_rem;
            word_q   <= in_word;
            // Only SPECIAL relies on this; MUL/DIV overwrite it on the way to DONE.
            result_q <= special_res;
        end else if (!flush) begin
            if ((state_q == S_MUL) && (mul_cnt_q == '0)) begin
                result_q <= mul_pipe_q[MUL_LAT-1];
            end else if ((state_q == S_DIV) && div_done) begin
                result_q <= div_res;
            end
        end
    end

    assign out_valid  = (state_q == S_DONE);
    assign out_result = out_valid ? result_q : '0;
    assign out_tag    = out_valid ? tag_q : '0;

endmodule

// File: tb/tb_exec_muldiv.sv
// tb/tb_exec_muldiv.sv - directed self-checking bench for exec_muldiv
module tb_exec_muldiv;
    import muldiv_ops::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    muldiv_op_t  in_op;
    logic        in_word;
    logic [63:0] in_a, in_b;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exec_muldiv #(
        .XLEN     (64),
        .DIV_STEP (2),
        .MUL_LAT  (2),
        .TAG_W    (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_word    (in_word),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    task automatic issue(input muldiv_op_t op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag);
        in_op = op; in_word = word; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic run_op(input muldiv_op_t op, input logic word, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] tag,
                          output int cyc, output logic [63:0] res, output logic [4:0] tg);
        issue(op, word, a, b, tag);
        wait_valid(cyc);
        res = out_result;
        tg  = out_tag;
        if (cyc > 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_op = OP_MUL; in_word = 1'b0; in_a = 64'd3; in_b = 64'd4; in_tag = 5'd7;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++;
        if (out_result !== 64'd0) begin failures++; $display("FAIL reset_out_result got %h expected 0", out_result); end
        checks++;
        if (out_tag !== 5'd0) begin failures++; $display("FAIL reset_out_tag got %h expected 0", out_tag); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_release got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_mul;
        muldiv_op_t  ops [7] = '{OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU, OP_MULH, OP_MUL, OP_MULHU};
        logic        wv  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [63:0] av  [7] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                                 64'h1234_5678_7FFF_FFFF, 64'd5};
        logic [63:0] bv  [7] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd2, 64'd7};
        logic [63:0] ev  [7] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'd1, 64'd0,
                                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'hFFFF_FFFF_FFFF_FFFE, 64'd0};
        int cyc;
        logic [63:0] res;
        logic [4:0]  tg;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], wv[i], av[i], bv[i], 5'(i + 3), cyc, res, tg);
            checks++;
            if (res !== ev[i]) begin failures++; $display("FAIL mul_result[%0d] got %h expected %h", i, res, ev[i]); end
            checks++;
            if (cyc != 2) begin failures++; $display("FAIL mul_latency[%0d] got %0d expected 2", i, cyc); end
            checks++;
            if (tg !== 5'(i + 3)) begin failures++; $display("FAIL mul_tag[%0d] got %h expected %h", i, tg, 5'(i + 3)); end
        end
    endtask

    task automatic test_div;
        muldiv_op_t  ops [9] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_DIVU, OP_REM, OP_DIV, OP_DIVU};
        logic        wv  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [63:0] av  [9] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'd100,
                                 64'hABCD_0000_FFFF_FFF9, 64'h0000_0000_FFFF_FFFF, 64'd7, 64'd7,
                                 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] bv  [9] = '{64'd2, 64'd2, 64'd7, 64'd7, 64'd2, 64'd1,
                                 64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'd16};
        logic [63:0] ev  [9] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd14, 64'd2,
                                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                                 64'hFFFF_FFFF_FFFF_FFFD, 64'h0FFF_FFFF_FFFF_FFFF};
        int          lv  [9] = '{33, 33, 33, 33, 17, 17, 17, 33, 33};
        int cyc;
        logic [63:0] res;
        logic [4:0]  tg;
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], wv[i], av[i], bv[i], 5'(i + 10), cyc, res, tg);
            checks++;
            if (res !== ev[i]) begin failures++; $display("FAIL div_result[%0d] got %h expected %h", i, res, ev[i]); end
            checks++;
            if (cyc != lv[i]) begin failures++; $display("FAIL div_latency[%0d] got %0d expected %0d", i, cyc, lv[i]); end
            checks++;
            if (tg !== 5'(i + 10)) begin failures++; $display("FAIL div_tag[%0d] got %h expected %h", i, tg, 5'(i + 10)); end
        end
    endtask

    task automatic test_special;
        muldiv_op_t  ops [8] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_REM};
        logic        wv  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] av  [8] = '{64'd5, 64'h0000_0001_8000_0001, 64'h8000_0000_0000_0000,
                                 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000,
                                 64'h0000_0000_8000_0000, 64'd9, 64'hFFFF_FFFF_FFFF_FFFB};
        logic [63:0] bv  [8] = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'h0000_0007_0000_0000, 64'd0};
        logic [63:0] ev  [8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001,
                                 64'h8000_0000_0000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 64'd0,
                                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB};
        int cyc;
        logic [63:0] res;
        logic [4:0]  tg;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], wv[i], av[i], bv[i], 5'(i + 20), cyc, res, tg);
            checks++;
            if (res !== ev[i]) begin failures++; $display("FAIL special_result[%0d] got %h expected %h", i, res, ev[i]); end
            checks++;
            if (cyc != 1) begin failures++; $display("FAIL special_latency[%0d] got %0d expected 1", i, cyc); end
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        out_ready = 1'b0;
        issue(OP_MUL, 1'b0, 64'd6, 64'd7, 5'h15);
        wait_valid(cyc);
        checks++;
        if (cyc != 2) begin failures++; $display("FAIL bp_latency got %0d expected 2", cyc); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== 64'd42 || out_tag !== 5'h15 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] got valid=%b result=%h tag=%h in_ready=%b expected 1/2a/15/0",
                         i, out_valid, out_result, out_tag, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++; $display("FAIL bp_handshake_cycle got in_ready=%b out_valid=%b expected 0/1", in_ready, out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 64'd0 || out_tag !== 5'd0) begin
            failures++;
            $display("FAIL bp_after got in_ready=%b out_valid=%b result=%h tag=%h expected 1/0/0/0",
                     in_ready, out_valid, out_result, out_tag);
        end
    endtask

    task automatic test_flush;
        int cyc;
        int seen;
        logic [63:0] res;
        logic [4:0]  tg;
        issue(OP_DIVU, 1'b0, 64'd100, 64'd7, 5'd4);
        seen = 0;
        repeat (9) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_idle got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL flush_no_output got %0d valid cycles expected 0", seen); end
        in_op = OP_MUL; in_word = 1'b0; in_a = 64'd3; in_b = 64'd3; in_tag = 5'd9;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        seen = 0;
        repeat (5) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++; $display("FAIL flush_beats_valid got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        run_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 5'd5, cyc, res, tg);
        checks++;
        if (res !== 64'd14 || cyc != 33 || tg !== 5'd5) begin
            failures++; $display("FAIL flush_next_op got result=%h cyc=%0d tag=%h expected e/33/5", res, cyc, tg);
        end
    endtask

    task automatic test_reset_mid_op;
        int cyc;
        int seen;
        logic [63:0] res;
        logic [4:0]  tg;
        issue(OP_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 64'd0) begin
            failures++; $display("FAIL rst_mid_mul got out_valid=%b in_ready=%b result=%h expected 0/1/0",
                                 out_valid, in_ready, out_result);
        end
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL rst_no_output got %0d valid cycles expected 0", seen); end
        run_op(OP_MUL, 1'b0, 64'd6, 64'd7, 5'd2, cyc, res, tg);
        checks++;
        if (res !== 64'd42 || cyc != 2 || tg !== 5'd2) begin
            failures++; $display("FAIL rst_next_op got result=%h cyc=%0d tag=%h expected 2a/2/2", res, cyc, tg);
        end
    endtask

    initial begin
        in_valid = 1'b0; in_op = OP_MUL; in_word = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b1; rst = 1'b0;
        test_reset;
        test_mul;
        test_div;
        test_special;
        test_backpressure;
        test_flush;
        test_reset_mid_op;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
